// File: rtl/data_sampler.sv
// UART RX oversampling front end: 3-sample mid-bit majority vote, edge/bit counters, frame wrap pulse.
// Define UART_RX_SYNC_EN to pass RX_IN through a two-flop synchronizer (adds 2 cycles line-to-sample).
module data_sampler #(
  parameter int FRAME_BITS = 11,
  parameter int PRESC_W    = 6
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               Dat_samp_EN,
  output logic               Sampled_bit,
  output logic               Sample_valid,
  output logic [PRESC_W-1:0] Edge_cnt,
  output logic [3:0]         Bit_cnt,
  output logic               Frame_done
);

  logic [PRESC_W-1:0] p_eff;
  logic [PRESC_W-1:0] half;
  logic [PRESC_W-1:0] last_edge;
  logic               rx_s;
  logic               s0;
  logic               s1;
  logic               wrap;
  logic               last_bit;
  logic               third_sample;
  logic               majority;

  // Unsupported ratios fall back to 8; decoded live so a change takes effect next cycle.
  always_comb begin
    p_eff = PRESC_W'(8);
    if (Prescale == PRESC_W'(16) || Prescale == PRESC_W'(32)) begin
      p_eff = Prescale;
    end
    half         = p_eff >> 1;
    last_edge    = p_eff - PRESC_W'(1);
    wrap         = (Edge_cnt >= last_edge);
    last_bit     = (Bit_cnt == 4'(FRAME_BITS - 1));
    third_sample = (Edge_cnt == half + PRESC_W'(1));
    majority     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  end

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RX_IN};
    end
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = RX_IN;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      Sampled_bit  <= 1'b1;
      Sample_valid <= 1'b0;
      Edge_cnt     <= '0;
      Bit_cnt      <= '0;
      Frame_done   <= 1'b0;
      s0           <= 1'b1;
      s1           <= 1'b1;
    end else begin
      // The third-sample commit lands even if the enable drops in that same cycle.
      if (third_sample) begin
        Sampled_bit <= majority;
      end
      if (!Dat_samp_EN) begin
        Sample_valid <= 1'b0;
        Edge_cnt     <= '0;
        Bit_cnt      <= '0;
        Frame_done   <= 1'b0;
        s0           <= 1'b0;
        s1           <= 1'b0;
      end else begin
        Sample_valid <= third_sample;
        Frame_done   <= wrap && last_bit;
        if (wrap) begin
          Edge_cnt <= '0;
          Bit_cnt  <= last_bit ? 4'd0 : Bit_cnt + 4'd1;
        end else begin
          Edge_cnt <= Edge_cnt + PRESC_W'(1);
        end
        if (Edge_cnt == half - PRESC_W'(1)) begin
          s0 <= rx_s;
        end
        if (Edge_cnt == half) begin
          s1 <= rx_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sampler.sv
// Self-checking bench for data_sampler: directed scenarios plus randomized runs against a
// cycle-index reference model (edge = n mod P, bit = n div P, majority of three mid-bit line values).
module tb_data_sampler;
  localparam int FB = 11;
  localparam int PW = 6;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] Prescale = PW'(8);
  logic          Dat_samp_EN = 1'b0;
  logic          Sampled_bit;
  logic          Sample_valid;
  logic [PW-1:0] Edge_cnt;
  logic [3:0]    Bit_cnt;
  logic          Frame_done;

  data_sampler #(.FRAME_BITS(FB), .PRESC_W(PW)) dut (
    .Clk(Clk), .Rst(Rst), .RX_IN(RX_IN), .Prescale(Prescale), .Dat_samp_EN(Dat_samp_EN),
    .Sampled_bit(Sampled_bit), .Sample_valid(Sample_valid), .Edge_cnt(Edge_cnt),
    .Bit_cnt(Bit_cnt), .Frame_done(Frame_done)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passed = 0;
  bit exp_bit = 1'b1;
  bit hist[$];
  bit dut_bits[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input bit rx, input bit en, input bit rst, input int presc);
    RX_IN = rx; Dat_samp_EN = en; Rst = rst; Prescale = PW'(presc);
    hist.push_back(rx);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  function automatic bit maj(input bit a, input bit b, input bit c);
    return (int'(a) + int'(b) + int'(c)) >= 2;
  endfunction

  // Line value the DUT sees in run-relative cycle k.
  function automatic bit eff(input int base, input int k);
    return hist[base + k - LAT];
  endfunction

  task automatic run(input int presc, input int len, input bit pat[$]);
    int p, h, base;
    bit v;
    p = (presc == 16 || presc == 32) ? presc : 8;
    h = p / 2;
    base = hist.size();
    dut_bits = {};
    for (int n = 0; n <= len; n++) begin
      v = ((n % p) == h + 2);
      if (v) exp_bit = maj(eff(base, n - 3), eff(base, n - 2), eff(base, n - 1));
      chk("edge_cnt", Edge_cnt, n % p);
      chk("bit_cnt", Bit_cnt, (n / p) % FB);
      chk("sample_valid", Sample_valid, v);
      chk("frame_done", Frame_done, (n > 0) && (n % (p * FB) == 0));
      chk("sampled_bit", Sampled_bit, exp_bit);
      if (Sample_valid) dut_bits.push_back(Sampled_bit);
      if (n < len) tick(pat[n], 1'b1, 1'b1, presc);
      else tick(1'b1, 1'b0, 1'b1, presc);
    end
    if ((len % p) == h + 1) exp_bit = maj(eff(base, len - 2), eff(base, len - 1), eff(base, len));
    chk("dis_edge_cnt", Edge_cnt, 0);
    chk("dis_bit_cnt", Bit_cnt, 0);
    chk("dis_sample_valid", Sample_valid, 0);
    chk("dis_frame_done", Frame_done, 0);
    chk("dis_sampled_bit", Sampled_bit, exp_bit);
  endtask

  initial begin
    bit pat[$];
    bit frame[11];
    int plist[6];
    int presc, p, len;
    bit cur;
    frame = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
    plist = '{8, 16, 32, 12, 0, 63};
    @(negedge Clk);

    // Reset holds everything despite enable and a low line.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 8);
    chk("rst_sampled_bit", Sampled_bit, 1);
    chk("rst_edge_cnt", Edge_cnt, 0);
    chk("rst_bit_cnt", Bit_cnt, 0);
    chk("rst_sample_valid", Sample_valid, 0);
    chk("rst_frame_done", Frame_done, 0);
    exp_bit = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 8);

    // P=8, steady low line across three bits.
    pat = {};
    for (int i = 0; i < 24; i++) pat.push_back(1'b0);
    run(8, 24, pat);
    chk("p8_low_sampled", Sampled_bit, 0);

    // P=16 single-cycle glitch at edge 8 is voted out.
    pat = {};
    for (int i = 0; i < 20; i++) pat.push_back(1'b1);
    pat[8 - LAT] = 1'b0;
    run(16, 20, pat);
    chk("glitch_sampled", Sampled_bit, 1);

    // P=16 low at edges 7 and 8 wins the vote.
    pat = {};
    for (int i = 0; i < 20; i++) pat.push_back(1'b1);
    pat[7 - LAT] = 1'b0;
    pat[8 - LAT] = 1'b0;
    run(16, 20, pat);
    chk("two_low_sampled", Sampled_bit, 0);

    // Full 0x55 frame, even parity, stop bit.
    pat = {};
    for (int b = 0; b < FB; b++)
      for (int i = 0; i < 16; i++) pat.push_back(frame[b]);
    for (int i = 0; i < 4; i++) pat.push_back(1'b1);
    run(16, 180, pat);
    chk("frame_pulses", dut_bits.size(), FB);
    for (int b = 0; b < FB; b++)
      if (b < dut_bits.size()) chk($sformatf("frame_bit%0d", b), dut_bits[b], frame[b]);

    // Illegal prescale 12 acts as 8; disable at edge 5 of the second bit.
    pat = {};
    for (int i = 0; i < 13; i++) pat.push_back(1'b0);
    run(12, 13, pat);
    chk("dis_mid_sampled", Sampled_bit, 0);

    // Reset mid-frame at the third-sample edge commits nothing.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1, 8);
    chk("pre_rst_edge_cnt", Edge_cnt, 5);
    tick(1'b1, 1'b1, 1'b0, 8);
    exp_bit = 1'b1;
    chk("midrst_edge_cnt", Edge_cnt, 0);
    chk("midrst_bit_cnt", Bit_cnt, 0);
    chk("midrst_sample_valid", Sample_valid, 0);
    chk("midrst_sampled_bit", Sampled_bit, 1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 8);

`ifdef UART_RX_SYNC_EN
    // Line falls in cycle 2: synchronized sample at edge 3 still high, 4 and 5 low.
    pat = '{1, 1, 0, 0, 0, 0, 0, 0};
    run(8, 8, pat);
    chk("sync_sampled", Sampled_bit, 0);
`endif

    // Randomized runs with bursty line activity and assorted prescale values.
    for (int r = 0; r < 8; r++) begin
      presc = plist[$urandom_range(0, 5)];
      p = (presc == 16 || presc == 32) ? presc : 8;
      len = $urandom_range(2 * p, p * FB + 2 * p);
      pat = {};
      cur = 1'b1;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) cur = ~cur;
        pat.push_back(cur);
      end
      run(presc, len, pat);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
